// File: rtl/hs_tx_queue.sv
// Circular 32-bit transmit queue with a three-phase offer/ack handshake
// (IDLE -> OFFER -> WAIT_RESP) toward a downstream slave.
module hs_tx_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          valid,
  output logic [31:0]   dout,
  input  logic          ready,
  input  logic          response
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OFFER     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count_nxt;
  logic           push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Write acceptance looks only at the current count, so a pop on the same
  // edge never makes room for a write that arrived while full.
  assign push = wr_en && !full;
  assign pop  = (state == WAIT_RESP) && response;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (count != '0) state_nxt = OFFER;
      OFFER:     if (ready)       state_nxt = WAIT_RESP;
      WAIT_RESP: if (response)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // The head slot cannot be overwritten while occupied, so dout is stable in OFFER.
  assign valid = (state == OFFER);
  assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_hs_tx_queue.sv
// Directed self-checking bench for hs_tx_queue (DEPTH=4).
module tb_hs_tx_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full, empty, overflow, valid;
  logic [2:0]  count;
  logic [31:0] dout;
  logic        ready, response;

  int checks = 0;
  int errors = 0;

  hs_tx_queue #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .valid    (valid),
    .dout     (dout),
    .ready    (ready),
    .response (response)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Wait (bounded) for an offer, check its data, then complete the handshake.
  task automatic drain_one(input logic [31:0] exp, input string tag);
    for (int i = 0; i < 8 && !valid; i++) tick();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_dout"}, dout, exp);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_wait_valid"}, 32'(valid), 32'd0);
    response = 1'b1;
    tick();
    response = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; ready = 1'b0; response = 1'b0;
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single entry: latency and one-cycle valid pulse
    write_one(32'hA5A5_0001);
    check("lat_count", 32'(count), 32'd1);
    check("lat_valid_n", 32'(valid), 32'd0);
    ready = 1'b1;
    tick();
    check("lat_valid", 32'(valid), 32'd1);
    check("lat_dout", dout, 32'hA5A5_0001);
    tick();
    check("one_valid_drop", 32'(valid), 32'd0);
    check("one_dout_zero", dout, 32'd0);
    response = 1'b1; ready = 1'b0;
    tick();
    response = 1'b0;
    check("one_count", 32'(count), 32'd0);
    check("one_empty", 32'(empty), 32'd1);
    tick();
    check("one_idle_valid", 32'(valid), 32'd0);

    // Fill to full, overflow, drop-while-popping
    write_one(32'd1);
    write_one(32'd2);
    write_one(32'd3);
    write_one(32'd4);
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd4);
    check("full_valid", 32'(valid), 32'd1);
    check("full_dout", dout, 32'd1);
    check("full_ovf0", 32'(overflow), 32'd0);
    write_one(32'd5);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_dout", dout, 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    wr_en = 1'b1; wr_data = 32'd6; response = 1'b1;
    tick();
    wr_en = 1'b0; response = 1'b0;
    check("full_pop_drop_count", 32'(count), 32'd3);
    drain_one(32'd2, "drain2");
    drain_one(32'd3, "drain3");
    drain_one(32'd4, "drain4");
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // ready/response ignored in the wrong states
    response = 1'b1;
    tick();
    response = 1'b0;
    check("resp_idle_valid", 32'(valid), 32'd0);
    check("resp_idle_count", 32'(count), 32'd0);
    write_one(32'hBEEF_0000);
    tick();
    check("ign_offer", 32'(valid), 32'd1);
    response = 1'b1;
    tick();
    response = 1'b0;
    check("resp_offer_valid", 32'(valid), 32'd1);
    check("resp_offer_count", 32'(count), 32'd1);
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    check("ready_wait_valid", 32'(valid), 32'd0);
    check("ready_wait_count", 32'(count), 32'd1);
    response = 1'b1;
    tick();
    response = 1'b0;
    check("ready_wait_pop", 32'(count), 32'd0);

    // Pointer wrap: six rounds of three writes then three drains
    for (int r = 0; r < 6; r++) begin
      write_one(32'h100 + 32'(r) * 16 + 1);
      write_one(32'h100 + 32'(r) * 16 + 2);
      write_one(32'h100 + 32'(r) * 16 + 3);
      check("wrap_count", 32'(count), 32'd3);
      drain_one(32'h100 + 32'(r) * 16 + 1, "wrap_a");
      drain_one(32'h100 + 32'(r) * 16 + 2, "wrap_b");
      drain_one(32'h100 + 32'(r) * 16 + 3, "wrap_c");
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Simultaneous write and pop in WAIT_RESP with count=2
    write_one(32'hC0DE_000A);
    write_one(32'hC0DE_000B);
    for (int i = 0; i < 8 && !valid; i++) tick();
    check("sim_head", dout, 32'hC0DE_000A);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("sim_pre_count", 32'(count), 32'd2);
    wr_en = 1'b1; wr_data = 32'hC0DE_000C; response = 1'b1;
    tick();
    wr_en = 1'b0; response = 1'b0;
    check("sim_count", 32'(count), 32'd2);
    drain_one(32'hC0DE_000B, "sim_b");
    drain_one(32'hC0DE_000C, "sim_c");

    // Asynchronous reset during OFFER with count=3
    write_one(32'd7);
    write_one(32'd8);
    write_one(32'd9);
    for (int i = 0; i < 8 && !valid; i++) tick();
    check("arst_pre_valid", 32'(valid), 32'd1);
    check("arst_pre_count", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_dout", dout, 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    #1 reset = 1'b1;
    tick();
    write_one(32'h0000_0077);
    drain_one(32'h0000_0077, "post_rst");
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_tx_queue.md
HS_TX_QUEUE -- requirements
Module: hs_tx_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of 32-bit entries held (power of two, >= 2).
REQ-002 SHALL provide parameter AW, default 2, pointer width = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clk.
REQ-005 wr_en  input  1  producer write strobe, one entry per cycle.
REQ-006 wr_data  input  32  producer data.
REQ-007 full  output  1  queue holds DEPTH entries.
REQ-008 empty  output  1  queue holds 0 entries.
REQ-009 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-010 overflow  output  1  sticky flag, write attempted while full.
REQ-011 valid  output  1  to downstream slave: head entry on dout is offered.
REQ-012 dout  output  32  head entry when valid=1, else 32'h0.
REQ-013 ready  input  1  from slave: slave accepts offered data.
REQ-014 response  input  1  from slave: slave has consumed data, transfer complete.

Function
REQ-015 SHALL store entries in a circular buffer with write and read pointers of AW bits that wrap from DEPTH-1 to 0.
REQ-016 SHALL accept a write when wr_en=1 and full=0; head of queue = oldest unpopped entry.
REQ-017 SHALL drop a write when wr_en=1 and full=1 (evaluated on the current count, even if a pop occurs in the same cycle), leave contents unchanged, and set overflow=1 until reset.
REQ-018 SHALL implement FSM states IDLE, OFFER, WAIT_RESP, held in a registered state variable.
REQ-019 IDLE: valid=0; next state OFFER when count>0, else IDLE.
REQ-020 OFFER: valid=1, dout=head; next state WAIT_RESP on an edge with ready=1, else OFFER; dout stays stable while in OFFER.
REQ-021 WAIT_RESP: valid=0, head retained; on an edge with response=1, pop head (read pointer+1, count-1) and go to IDLE; else remain.
REQ-022 SHALL ignore response outside WAIT_RESP and ignore ready outside OFFER.
REQ-023 SHALL decode valid and dout from the registered state only, with no combinational path from ready/response to valid.
REQ-024 Latency: a write at edge N into an empty IDLE queue gives count=1 after edge N, state OFFER and valid=1 after edge N+1.
REQ-025 Simultaneous accepted write and pop on one edge SHALL leave count unchanged and advance both pointers.
REQ-026 full=(count==DEPTH) and empty=(count==0) SHALL be combinational from count.
REQ-027 Minimum turnaround per entry SHALL be 3 cycles (OFFER, WAIT_RESP, IDLE), so back-to-back entries are offered at most once every 3 cycles.

Reset
REQ-028 While reset=0: state=IDLE, pointers=0, count=0, overflow=0, valid=0, dout=0, empty=1, full=0; storage contents are don't-care.
REQ-029 Reset asserted in OFFER or WAIT_RESP SHALL abandon the in-flight entry and all queued entries without a pop handshake.

Verification
REQ-030 Write 32'hA5A5_0001 to empty queue, hold ready=1, pulse response 1 cycle in WAIT_RESP -> valid high exactly 1 cycle with dout=32'hA5A5_0001, then count returns 0 and empty=1.
REQ-031 Write 4 entries 1,2,3,4 back-to-back with ready=0 -> full=1, count=4, valid=1 with dout=1 held; a 5th write of 5 sets overflow=1 and is dropped; draining yields 1,2,3,4 in order.
REQ-032 Six write/drain cycles through DEPTH=4 -> pointer wrap; data order preserved, count never exceeds 4.
REQ-033 In WAIT_RESP with count=2, write and response on the same edge -> count stays 2, next offered dout is the second entry.
REQ-034 response=1 in IDLE and ready=1 in WAIT_RESP -> no pop, no state change.
REQ-035 Drive reset low mid-OFFER with count=3 -> valid=0, count=0, empty=1 without waiting for a clock edge; a new write after release is offered normally.
